// File: rtl/axi_sample_bridge_p.sv
// axi_sample_bridge_p
//  Collects a block of N samples from a valid/ready write channel into the FFT
//  working RAM. Once the core reports completion, it reads the N results back
//  and streams them out on a valid/ready read channel. A small FIFO with credit
//  accounting absorbs RAM read latency so downstream back-pressure never drops
//  a beat.
// Ports
//  i_clk, i_rst                clock, asynchronous active-high reset
//  i_SAMPLES_NUMBER, i_BITREV  block length N and read-out order, sampled on first write
//  i_AWDATA/i_AWVALID/o_AWREADY  sample input channel
//  o_SAMPLE_ram, o_SAMPLE_INDEX_ram, o_WRITE_ram, o_READ_ram, i_DATA_FROM_RAM  RAM side
//  o_DATA_LOADED, i_CALC_END   handshake with the FFT core
//  o_ARDATA/o_ARVALID/i_ARREADY/o_ARLAST  result output channel
//  o_ERR                       one-cycle pulse when N is out of range
module axi_sample_bridge_p #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned RD_LATENCY   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDR_WIDTH:0]     i_SAMPLES_NUMBER,
    input  logic                    i_BITREV,
    input  logic [SAMPLE_WIDTH-1:0] i_AWDATA,
    input  logic                    i_AWVALID,
    output logic                    o_AWREADY,
    output logic [SAMPLE_WIDTH-1:0] o_SAMPLE_ram,
    output logic [ADDR_WIDTH-1:0]   o_SAMPLE_INDEX_ram,
    output logic                    o_WRITE_ram,
    output logic                    o_READ_ram,
    input  logic [DATA_WIDTH-1:0]   i_DATA_FROM_RAM,
    output logic                    o_DATA_LOADED,
    input  logic                    i_CALC_END,
    output logic [DATA_WIDTH-1:0]   o_ARDATA,
    output logic                    o_ARVALID,
    input  logic                    i_ARREADY,
    output logic                    o_ARLAST,
    output logic                    o_ERR
);

    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = RD_LATENCY + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned LOG_W = $clog2(ADDR_WIDTH + 1);
    localparam logic [CW-1:0] N_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN} state_t;

    state_t                  state;
    logic [CW-1:0]           n_reg;
    logic [CW-1:0]           cnt;        // write index in LOAD, read issue index in DRAIN
    logic [CW-1:0]           beat;       // beats accepted downstream
    logic                    bitrev_q;
    logic [LOG_W-1:0]        log_q;
    logic                    err_blk;    // limits o_ERR to one pulse per bad request
    logic [DATA_WIDTH-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [OCC_W-1:0]        occ;
    logic [OCC_W-1:0]        credits;    // FIFO occupancy plus reads still in flight
    logic [RD_LATENCY-1:0]   rd_pipe;

    logic                    n_ok;
    logic                    n_pow2;
    logic [LOG_W-1:0]        n_log;
    logic                    aw_hs;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [ADDR_WIDTH-1:0]   rev_full;
    logic [ADDR_WIDTH-1:0]   rd_idx;

    assign n_ok   = (i_SAMPLES_NUMBER != '0) && (i_SAMPLES_NUMBER <= N_MAX);
    assign n_pow2 = ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - CW'(1))) == '0);
    assign aw_hs  = i_AWVALID && o_AWREADY && ((state == S_LOAD) || n_ok);
    assign pop    = o_ARVALID && i_ARREADY;
    assign push   = rd_pipe[RD_LATENCY-1];
    assign issue  = (state == S_DRAIN) && (cnt < n_reg)
                    && ((credits - OCC_W'(pop)) < OCC_W'(DEPTH));

    assign o_ARVALID = (occ != '0);
    assign o_ARDATA  = fifo_mem[rd_ptr];
    assign o_ARLAST  = o_ARVALID && (beat == n_reg - CW'(1));

    // log2 of N; exact whenever N is a power of two
    always_comb begin
        n_log = '0;
        for (int i = 0; i < CW; i++) begin
            if (i_SAMPLES_NUMBER[i]) n_log = LOG_W'(i);
        end
    end

    // Read index: reverse all address bits, then drop the unused upper ones
    always_comb begin
        rev_full = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            rev_full[i] = cnt[ADDR_WIDTH-1-i];
        end
        rd_idx = bitrev_q ? (rev_full >> (LOG_W'(ADDR_WIDTH) - log_q)) : ADDR_WIDTH'(cnt);
    end

    // Control FSM with registered RAM-side and handshake outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state              <= S_IDLE;
            n_reg              <= '0;
            cnt                <= '0;
            beat               <= '0;
            bitrev_q           <= 1'b0;
            log_q              <= '0;
            err_blk            <= 1'b0;
            o_AWREADY          <= 1'b0;
            o_SAMPLE_ram       <= '0;
            o_SAMPLE_INDEX_ram <= '0;
            o_WRITE_ram        <= 1'b0;
            o_READ_ram         <= 1'b0;
            o_DATA_LOADED      <= 1'b0;
            o_ERR              <= 1'b0;
        end else begin
            o_WRITE_ram <= 1'b0;
            o_READ_ram  <= 1'b0;
            o_ERR       <= 1'b0;
            err_blk     <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_AWREADY <= n_ok;
                    err_blk   <= i_AWVALID && !n_ok;
                    o_ERR     <= i_AWVALID && !n_ok && !err_blk;
                    if (aw_hs) begin
                        n_reg              <= i_SAMPLES_NUMBER;
                        bitrev_q           <= i_BITREV && n_pow2;
                        log_q              <= n_log;
                        o_WRITE_ram        <= 1'b1;
                        o_SAMPLE_ram       <= i_AWDATA;
                        o_SAMPLE_INDEX_ram <= '0;
                        cnt                <= CW'(1);
                        if (i_SAMPLES_NUMBER == CW'(1)) begin
                            state         <= S_WAIT;
                            o_AWREADY     <= 1'b0;
                            o_DATA_LOADED <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (aw_hs) begin
                        o_WRITE_ram        <= 1'b1;
                        o_SAMPLE_ram       <= i_AWDATA;
                        o_SAMPLE_INDEX_ram <= ADDR_WIDTH'(cnt);
                        cnt                <= cnt + CW'(1);
                        if (cnt == n_reg - CW'(1)) begin
                            state         <= S_WAIT;
                            o_AWREADY     <= 1'b0;
                            o_DATA_LOADED <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_CALC_END) begin
                        state         <= S_DRAIN;
                        o_DATA_LOADED <= 1'b0;
                        cnt           <= '0;
                        beat          <= '0;
                    end
                end
                S_DRAIN: begin
                    if (issue) begin
                        o_READ_ram         <= 1'b1;
                        o_SAMPLE_INDEX_ram <= rd_idx;
                        cnt                <= cnt + CW'(1);
                    end
                    if (pop) begin
                        beat <= beat + CW'(1);
                        if (beat == n_reg - CW'(1)) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM latency pipe, result FIFO and credit accounting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_pipe <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            credits <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            rd_pipe[0] <= o_READ_ram;
            for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (push) begin
                fifo_mem[wr_ptr] <= i_DATA_FROM_RAM;
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            occ     <= occ + OCC_W'(push) - OCC_W'(pop);
            credits <= credits + OCC_W'(issue) - OCC_W'(pop);
        end
    end

endmodule

// File: tb/tb_axi_sample_bridge_p.sv
// tb_axi_sample_bridge_p
//  Directed bench for axi_sample_bridge_p (RD_LATENCY=2, ADDR_WIDTH=12).
//  A RAM model returns 2*index. Inputs change on the falling edge; a monitor
//  logs DUT activity on the rising edge for the test tasks to compare.
module tb_axi_sample_bridge_p;

    localparam int unsigned SW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 12;
    localparam int unsigned LAT = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [AW:0]   i_SAMPLES_NUMBER = '0;
    logic          i_BITREV = 1'b0;
    logic [SW-1:0] i_AWDATA = '0;
    logic          i_AWVALID = 1'b0;
    logic          o_AWREADY;
    logic [SW-1:0] o_SAMPLE_ram;
    logic [AW-1:0] o_SAMPLE_INDEX_ram;
    logic          o_WRITE_ram;
    logic          o_READ_ram;
    logic [DW-1:0] i_DATA_FROM_RAM;
    logic          o_DATA_LOADED;
    logic          i_CALC_END = 1'b0;
    logic [DW-1:0] o_ARDATA;
    logic          o_ARVALID;
    logic          i_ARREADY = 1'b0;
    logic          o_ARLAST;
    logic          o_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    axi_sample_bridge_p #(
        .SAMPLE_WIDTH(SW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER), .i_BITREV(i_BITREV),
        .i_AWDATA(i_AWDATA), .i_AWVALID(i_AWVALID), .o_AWREADY(o_AWREADY),
        .o_SAMPLE_ram(o_SAMPLE_ram), .o_SAMPLE_INDEX_ram(o_SAMPLE_INDEX_ram),
        .o_WRITE_ram(o_WRITE_ram), .o_READ_ram(o_READ_ram),
        .i_DATA_FROM_RAM(i_DATA_FROM_RAM), .o_DATA_LOADED(o_DATA_LOADED),
        .i_CALC_END(i_CALC_END), .o_ARDATA(o_ARDATA), .o_ARVALID(o_ARVALID),
        .i_ARREADY(i_ARREADY), .o_ARLAST(o_ARLAST), .o_ERR(o_ERR)
    );

    always #5 i_clk = ~i_clk;

    // RAM model: data = 2*index, valid exactly LAT cycles after the strobe
    logic [DW-1:0] rpipe [LAT];
    always @(posedge i_clk) begin
        rpipe[0] <= o_READ_ram ? DW'({o_SAMPLE_INDEX_ram, 1'b0}) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign i_DATA_FROM_RAM = rpipe[LAT-1];

    // Activity logs
    logic [AW-1:0] wr_idx_q [$];
    logic [SW-1:0] wr_dat_q [$];
    logic [AW-1:0] rd_idx_q [$];
    logic [DW-1:0] bt_dat_q [$];
    logic          bt_last_q [$];
    int            overlap_cnt = 0;
    int            hold_err = 0;
    int            err_cycles = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge i_clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (o_WRITE_ram) begin
                wr_idx_q.push_back(o_SAMPLE_INDEX_ram);
                wr_dat_q.push_back(o_SAMPLE_ram);
            end
            if (o_READ_ram) rd_idx_q.push_back(o_SAMPLE_INDEX_ram);
            if (o_WRITE_ram && o_READ_ram) overlap_cnt++;
            if (o_ERR) err_cycles++;
            if (prev_stall && (!o_ARVALID || (o_ARDATA !== prev_data))) hold_err++;
            if (o_ARVALID && i_ARREADY) begin
                bt_dat_q.push_back(o_ARDATA);
                bt_last_q.push_back(o_ARLAST);
            end
            prev_stall = o_ARVALID && !i_ARREADY;
            prev_data  = o_ARDATA;
        end
    end

    task automatic clear_logs();
        wr_idx_q.delete(); wr_dat_q.delete(); rd_idx_q.delete();
        bt_dat_q.delete(); bt_last_q.delete();
        overlap_cnt = 0; hold_err = 0; err_cycles = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Offer n samples d0, d0+1, ...; returns how many were accepted
    task automatic load_block(input int n, input int d0, output int acc);
        int t;
        logic hs;
        acc = 0; t = 0;
        i_AWVALID = 1'b1;
        i_AWDATA  = SW'(d0);
        while (acc < n && t < n * 4 + 20) begin
            hs = o_AWREADY;
            @(negedge i_clk);
            t++;
            if (hs) begin
                acc++;
                i_AWDATA = SW'(d0 + acc);
            end
        end
        i_AWVALID = 1'b0;
        @(negedge i_clk);
    endtask

    // Pulse CALC_END, then accept beats until n collected or time runs out
    task automatic drain(input int n, input bit stall);
        int t;
        t = 0;
        i_CALC_END = 1'b1;
        @(negedge i_clk);
        i_CALC_END = 1'b0;
        while (bt_dat_q.size() < n && t < n * 6 + 50) begin
            i_ARREADY = stall ? ((t % 3) == 0) : 1'b1;
            @(negedge i_clk);
            t++;
        end
        i_ARREADY = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle(3);
        n_cmp++;
        if ({o_AWREADY, o_WRITE_ram, o_READ_ram, o_DATA_LOADED, o_ARVALID, o_ARLAST, o_ERR} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {o_AWREADY, o_WRITE_ram, o_READ_ram, o_DATA_LOADED, o_ARVALID, o_ARLAST, o_ERR});
        end
        n_cmp++;
        if ({o_SAMPLE_ram, o_SAMPLE_INDEX_ram, o_ARDATA} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {o_SAMPLE_ram, o_SAMPLE_INDEX_ram, o_ARDATA});
        end
        i_rst = 1'b0;
        idle(2);
    endtask

    task automatic test_load();
        int acc;
        i_SAMPLES_NUMBER = 13'd10; i_BITREV = 1'b0;
        idle(2);
        clear_logs();
        load_block(10, 1, acc);
        n_cmp++;
        if (wr_idx_q.size() !== 10) begin
            n_bad++; $display("FAIL load_count: got %0d want 10", wr_idx_q.size());
        end
        for (int k = 0; k < wr_idx_q.size() && k < 10; k++) begin
            n_cmp++;
            if (wr_idx_q[k] !== AW'(k) || wr_dat_q[k] !== SW'(k + 1)) begin
                n_bad++;
                $display("FAIL load_write[%0d]: got idx %0d data %0d want idx %0d data %0d",
                         k, wr_idx_q[k], wr_dat_q[k], k, k + 1);
            end
        end
        n_cmp++;
        if (o_DATA_LOADED !== 1'b1 || o_AWREADY !== 1'b0) begin
            n_bad++; $display("FAIL load_done: got loaded %b ready %b want 1 0", o_DATA_LOADED, o_AWREADY);
        end
        // AWVALID is ignored while waiting for the core
        i_AWVALID = 1'b1;
        idle(4);
        i_AWVALID = 1'b0;
        idle(1);
        n_cmp++;
        if (wr_idx_q.size() !== 10 || o_AWREADY !== 1'b0 || o_DATA_LOADED !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_ignore_aw: got writes %0d ready %b loaded %b want 10 0 1",
                     wr_idx_q.size(), o_AWREADY, o_DATA_LOADED);
        end
    endtask

    task automatic test_drain_full();
        clear_logs();
        drain(10, 1'b0);
        n_cmp++;
        if (bt_dat_q.size() !== 10) begin
            n_bad++; $display("FAIL drain_count: got %0d want 10", bt_dat_q.size());
        end
        for (int k = 0; k < bt_dat_q.size() && k < 10; k++) begin
            n_cmp++;
            if (bt_dat_q[k] !== DW'(2 * k) || bt_last_q[k] !== (k == 9) || rd_idx_q[k] !== AW'(k)) begin
                n_bad++;
                $display("FAIL drain_beat[%0d]: got data %0d last %b idx %0d want %0d %b %0d",
                         k, bt_dat_q[k], bt_last_q[k], rd_idx_q[k], 2 * k, (k == 9), k);
            end
        end
        n_cmp++;
        if (o_DATA_LOADED !== 1'b0 || o_ARVALID !== 1'b0 || overlap_cnt !== 0 || rd_idx_q.size() !== 10) begin
            n_bad++;
            $display("FAIL drain_end: got loaded %b valid %b overlap %0d reads %0d want 0 0 0 10",
                     o_DATA_LOADED, o_ARVALID, overlap_cnt, rd_idx_q.size());
        end
    endtask

    task automatic test_back_pressure();
        int acc;
        load_block(10, 100, acc);
        clear_logs();
        drain(10, 1'b1);
        n_cmp++;
        if (bt_dat_q.size() !== 10 || hold_err !== 0) begin
            n_bad++;
            $display("FAIL stall_summary: got beats %0d hold_errors %0d want 10 0", bt_dat_q.size(), hold_err);
        end
        for (int k = 0; k < bt_dat_q.size() && k < 10; k++) begin
            n_cmp++;
            if (bt_dat_q[k] !== DW'(2 * k) || bt_last_q[k] !== (k == 9)) begin
                n_bad++;
                $display("FAIL stall_beat[%0d]: got data %0d last %b want %0d %b",
                         k, bt_dat_q[k], bt_last_q[k], 2 * k, (k == 9));
            end
        end
    endtask

    task automatic test_bitrev();
        int acc;
        int exp8 [8];
        exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};
        i_SAMPLES_NUMBER = 13'd8; i_BITREV = 1'b1;
        idle(2);
        load_block(8, 0, acc);
        clear_logs();
        drain(8, 1'b0);
        n_cmp++;
        if (rd_idx_q.size() !== 8 || bt_dat_q.size() !== 8) begin
            n_bad++;
            $display("FAIL bitrev8_count: got reads %0d beats %0d want 8 8", rd_idx_q.size(), bt_dat_q.size());
        end
        for (int k = 0; k < rd_idx_q.size() && k < bt_dat_q.size() && k < 8; k++) begin
            n_cmp++;
            if (rd_idx_q[k] !== AW'(exp8[k]) || bt_dat_q[k] !== DW'(2 * exp8[k])) begin
                n_bad++;
                $display("FAIL bitrev8[%0d]: got idx %0d data %0d want %0d %0d",
                         k, rd_idx_q[k], bt_dat_q[k], exp8[k], 2 * exp8[k]);
            end
        end
        // Non power of two falls back to natural order
        i_SAMPLES_NUMBER = 13'd6;
        idle(2);
        load_block(6, 0, acc);
        clear_logs();
        drain(6, 1'b0);
        n_cmp++;
        if (rd_idx_q.size() !== 6) begin
            n_bad++; $display("FAIL bitrev6_count: got %0d want 6", rd_idx_q.size());
        end
        for (int k = 0; k < rd_idx_q.size() && k < 6; k++) begin
            n_cmp++;
            if (rd_idx_q[k] !== AW'(k)) begin
                n_bad++; $display("FAIL bitrev6[%0d]: got idx %0d want %0d", k, rd_idx_q[k], k);
            end
        end
        i_BITREV = 1'b0;
    endtask

    task automatic test_range();
        int acc;
        int rdy_seen;
        int nvals [2];
        int lasts;
        nvals = '{0, 4097};
        // CALC_END outside WAIT does nothing
        clear_logs();
        i_CALC_END = 1'b1;
        idle(1);
        i_CALC_END = 1'b0;
        idle(4);
        n_cmp++;
        if (rd_idx_q.size() !== 0 || o_ARVALID !== 1'b0) begin
            n_bad++; $display("FAIL idle_calc_end: got reads %0d valid %b want 0 0", rd_idx_q.size(), o_ARVALID);
        end
        for (int v = 0; v < 2; v++) begin
            i_SAMPLES_NUMBER = 13'(nvals[v]);
            idle(2);
            clear_logs();
            rdy_seen = 0;
            i_AWVALID = 1'b1;
            repeat (4) begin
                @(negedge i_clk);
                if (o_AWREADY !== 1'b0) rdy_seen++;
            end
            i_AWVALID = 1'b0;
            idle(2);
            n_cmp++;
            if (err_cycles !== 1 || rdy_seen !== 0 || wr_idx_q.size() !== 0) begin
                n_bad++;
                $display("FAIL range_N%0d: got err_cycles %0d ready_cycles %0d writes %0d want 1 0 0",
                         nvals[v], err_cycles, rdy_seen, wr_idx_q.size());
            end
        end
        // Still in IDLE: a valid N brings AWREADY back
        i_SAMPLES_NUMBER = 13'd4096;
        idle(2);
        n_cmp++;
        if (o_AWREADY !== 1'b1) begin
            n_bad++; $display("FAIL range_recover: got ready %b want 1", o_AWREADY);
        end
        clear_logs();
        load_block(4096, 0, acc);
        n_cmp++;
        if (acc !== 4096 || wr_idx_q.size() !== 4096 || o_DATA_LOADED !== 1'b1) begin
            n_bad++;
            $display("FAIL nmax_load: got accepted %0d writes %0d loaded %b want 4096 4096 1",
                     acc, wr_idx_q.size(), o_DATA_LOADED);
        end
        n_cmp++;
        if (wr_idx_q.size() != 4096 || wr_idx_q[4095] !== 12'd4095 || err_cycles !== 0) begin
            n_bad++; $display("FAIL nmax_last_write: got writes %0d errs %0d want last idx 4095 errs 0",
                              wr_idx_q.size(), err_cycles);
        end
        clear_logs();
        drain(4096, 1'b0);
        lasts = 0;
        foreach (bt_last_q[k]) if (bt_last_q[k]) lasts++;
        n_cmp++;
        if (bt_dat_q.size() !== 4096 || lasts !== 1) begin
            n_bad++; $display("FAIL nmax_drain: got beats %0d lasts %0d want 4096 1", bt_dat_q.size(), lasts);
        end
        n_cmp++;
        if (bt_dat_q.size() != 4096 || bt_dat_q[4095] !== 32'd8190 || bt_last_q[4095] !== 1'b1) begin
            n_bad++; $display("FAIL nmax_final_beat: got beats %0d want final data 8190 with last", bt_dat_q.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int acc;
        int t;
        int late_valid;
        i_SAMPLES_NUMBER = 13'd10;
        idle(2);
        load_block(10, 0, acc);
        clear_logs();
        i_CALC_END = 1'b1;
        @(negedge i_clk);
        i_CALC_END = 1'b0;
        i_ARREADY = 1'b1;
        t = 0;
        while (bt_dat_q.size() < 3 && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        n_cmp++;
        if (bt_dat_q.size() !== 3) begin
            n_bad++; $display("FAIL midrst_progress: got beats %0d want 3", bt_dat_q.size());
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        n_cmp++;
        if ({o_AWREADY, o_WRITE_ram, o_READ_ram, o_DATA_LOADED, o_ARVALID, o_ARLAST, o_ERR} !== 7'b0
            || {o_SAMPLE_ram, o_SAMPLE_INDEX_ram, o_ARDATA} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got ctrl %b data %h want 0",
                     {o_AWREADY, o_WRITE_ram, o_READ_ram, o_DATA_LOADED, o_ARVALID, o_ARLAST, o_ERR},
                     {o_SAMPLE_ram, o_SAMPLE_INDEX_ram, o_ARDATA});
        end
        i_rst = 1'b0;
        late_valid = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_ARVALID !== 1'b0 || o_READ_ram !== 1'b0) late_valid++;
        end
        n_cmp++;
        if (late_valid !== 0) begin
            n_bad++; $display("FAIL midrst_stale: got %0d cycles with valid/read want 0", late_valid);
        end
        i_ARREADY = 1'b0;
        i_SAMPLES_NUMBER = 13'd4;
        idle(2);
        clear_logs();
        load_block(4, 20, acc);
        n_cmp++;
        if (wr_idx_q.size() !== 4 || o_DATA_LOADED !== 1'b1) begin
            n_bad++; $display("FAIL postrst_load: got writes %0d loaded %b want 4 1", wr_idx_q.size(), o_DATA_LOADED);
        end
        clear_logs();
        drain(4, 1'b0);
        n_cmp++;
        if (bt_dat_q.size() !== 4) begin
            n_bad++; $display("FAIL postrst_count: got %0d want 4", bt_dat_q.size());
        end
        for (int k = 0; k < bt_dat_q.size() && k < 4; k++) begin
            n_cmp++;
            if (bt_dat_q[k] !== DW'(2 * k) || bt_last_q[k] !== (k == 3)) begin
                n_bad++;
                $display("FAIL postrst_beat[%0d]: got data %0d last %b want %0d %b",
                         k, bt_dat_q[k], bt_last_q[k], 2 * k, (k == 3));
            end
        end
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_load();
        test_drain_full();
        test_back_pressure();
        test_bitrev();
        test_range();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
